norm_packer: RTL and testbench
==============================

# norm_packer

Receiving end of the normalizer output stream. The normalizer emits one normalized word per core per cycle (`psum_norm_1`, `psum_norm_2`, qualified by `norm_valid`). `norm_packer` reassembles each group of COL consecutive words into one COL-wide row per core. It buffers completed rows in a small FIFO and presents them to the downstream SFU/memory writer over a valid/ready handshake.

## Interface
Parameters:
- `BW_PSUM`, 16, psum width of the array (documentation only; not used in logic)
- `COL`, 8, words per packed row; must be ≥ 2
- `W_OUT`, `BW_PSUM`, width of each normalized word
- `DEPTH`, 2, output row FIFO entries; must be ≥ 1

Ports:
- `clk`  in  1  sole clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `norm_valid`  in  1  qualifies `psum_norm_1`/`psum_norm_2` this cycle
- `psum_norm_1`  in  W_OUT  normalized word, core 1
- `psum_norm_2`  in  W_OUT  normalized word, core 2
- `m_ready`  in  1  downstream accepts head row
- `m_valid`  out  1  head row available
- `row_1`  out  [COL-1:0][W_OUT-1:0]  head row, core 1; word k is the k-th word received
- `row_2`  out  [COL-1:0][W_OUT-1:0]  head row, core 2
- `fill_idx`  out  $clog2(COL)  words collected in the current partial row
- `overflow`  out  1  sticky: a completed row was dropped

## Operation
- FSM, 2 states:
  - IDLE: `fill_idx`==0.
  - FILL: 0<`fill_idx`<COL.
  - IDLE→FILL on `norm_valid` when COL>1.
  - FILL→IDLE on `norm_valid` with `fill_idx`==COL-1.
- On `norm_valid`:
  - Write `psum_norm_1` to `shadow_1[fill_idx]` and `psum_norm_2` to `shadow_2[fill_idx]`.
  - `fill_idx` increments, wrapping from COL-1 to 0.
- Gaps in `norm_valid` are allowed. A partial row holds indefinitely, with no timeout.
- Row completion: `norm_valid` with `fill_idx`==COL-1.
  - Push {shadow with the final word merged, both cores} into the FIFO.
  - The final word goes to word COL-1 of the pushed row, not via the shadow.
- FIFO full on push:
  - Without a same-cycle pop: drop the row, set `overflow`=1, and still wrap `fill_idx` to 0.
  - With a same-cycle pop (`m_valid`&&`m_ready`): accept the push. There is no drop.
- Output handshake:
  - `m_valid` = FIFO not empty.
  - `row_1`/`row_2` are the head entry and stay stable while `m_valid`&&!`m_ready`.
  - Pop on `m_valid`&&`m_ready`.
- `overflow` is cleared only by `reset`.
- Rows leave in arrival order. Core 1 and core 2 words are never mixed.

## Timing
- Reset values: `m_valid`=0, `fill_idx`=0, `overflow`=0, FIFO empty, FSM=IDLE.
- `row_1`/`row_2` are don't-care at reset; the bench compares them only when `m_valid`=1.
- Reset mid-row discards the partial row. The next `norm_valid` writes word 0.
- Latency: the final word is sampled at edge N, and `m_valid`=1 after edge N (the following cycle) when the FIFO was empty.
- Throughput: one row per COL cycles sustained with `m_ready`=1. No bubbles are inserted.
- Pop and push in the same cycle leave the occupancy unchanged.
- `m_valid` does not depend combinationally on `m_ready`.
- `row_1`, `row_2` and `m_valid` are driven from registers. There are no combinational paths from inputs to outputs.

## Configuration
- `NORM_PACKER_PARITY_EN` defined:
  - Adds output `row_parity` [1:0].
  - Bit 0 is the XOR of all bits of `row_1`; bit 1 is the XOR of all bits of `row_2`.
  - Parity is computed at push, stored in the FIFO alongside the row, and valid with `m_valid`.
  - Reset value is 0.
- Undefined: no `row_parity` port and no parity storage. All other behaviour is identical.

## Test plan
Scenarios use COL=8, W_OUT=16, DEPTH=2.
- Basic: release reset, hold `m_ready`=1, drive 8 consecutive `norm_valid` with `psum_norm_1`=10..17 and `psum_norm_2`=0..7.
  - Response: `m_valid`=1 for exactly one cycle, starting the cycle after the 8th word.
  - `row_1[k]`=10+k, `row_2[k]`=k, `fill_idx` back at 0.
- Gaps: drive the same 8 word pairs with 3 idle cycles between each.
  - Response: the same row contents as Basic.
  - `fill_idx` steps 1..7 and holds during the gaps.
- Backpressure/overflow: `m_ready`=0, push 3 rows (word values 0x100+k, 0x200+k, 0x300+k).
  - Response: `m_valid`=1 with the row 0x100 at the head, and `overflow`=1 after the 3rd row.
  - With `m_ready`=1, exactly rows 0x100 and 0x200 drain, in that order.
- Full + simultaneous pop: fill 2 rows, then assert `m_ready`=1 on the same cycle as the final word of a 3rd row.
  - Response: `overflow` stays 0, and 3 rows drain in order.
- Reset mid-row: feed 5 words, pulse `reset` for 1 cycle, then feed 8 words with value 0x50+k.
  - Response: one row, `row_1[k]`=0x50+k, with no residue from the pre-reset words.
- Parity (`NORM_PACKER_PARITY_EN`): `psum_norm_1`=0x0001 in word 0 and 0 elsewhere; `psum_norm_2`=0 throughout.
  - Response: `row_parity`=2'b01.

Source files
------------

// File: rtl/norm_packer.sv
// Packs COL consecutive normalized words per core into one row and queues rows
// for a valid/ready consumer. Optional row parity: define NORM_PACKER_PARITY_EN.
module norm_packer #(
    parameter int BW_PSUM = 16,
    parameter int COL     = 8,
    parameter int W_OUT   = BW_PSUM,
    parameter int DEPTH   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        norm_valid,
    input  logic [W_OUT-1:0]            psum_norm_1,
    input  logic [W_OUT-1:0]            psum_norm_2,
    input  logic                        m_ready,
    output logic                        m_valid,
    output logic [COL-1:0][W_OUT-1:0]   row_1,
    output logic [COL-1:0][W_OUT-1:0]   row_2,
    output logic [$clog2(COL)-1:0]      fill_idx,
    output logic                        overflow
`ifdef NORM_PACKER_PARITY_EN
    ,
    output logic [1:0]                  row_parity
`endif
);

    localparam int FW = $clog2(COL);

    typedef logic [COL-1:0][W_OUT-1:0] row_t;
    typedef enum logic {ST_IDLE, ST_FILL} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   fill_idx_q, fill_idx_d;
    row_t            shadow_1_q, shadow_1_d;
    row_t            shadow_2_q, shadow_2_d;
    row_t            push_row_1, push_row_2;
    row_t            mem_1_q [DEPTH];
    row_t            mem_1_d [DEPTH];
    row_t            mem_2_q [DEPTH];
    row_t            mem_2_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic            overflow_q, overflow_d;
    logic            last_word, row_done, pop, full, push_ok, drop, placed;
`ifdef NORM_PACKER_PARITY_EN
    logic [1:0]      par_q [DEPTH];
    logic [1:0]      par_d [DEPTH];
    logic [1:0]      push_par;
`endif

    assign last_word = (fill_idx_q == FW'(COL - 1));
    assign row_done  = norm_valid && last_word;

    // Collector FSM and word index
    always_comb begin
        state_d    = state_q;
        fill_idx_d = fill_idx_q;
        case (state_q)
            ST_IDLE: if (norm_valid && (COL > 1)) state_d = ST_FILL;
            ST_FILL: if (row_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (norm_valid) begin
            fill_idx_d = last_word ? '0 : fill_idx_q + 1'b1;
        end
    end

    // The final word bypasses the shadow so the row is pushed on the same edge.
    always_comb begin
        shadow_1_d = shadow_1_q;
        shadow_2_d = shadow_2_q;
        push_row_1 = shadow_1_q;
        push_row_2 = shadow_2_q;
        for (int k = 0; k < COL; k++) begin
            if (norm_valid && (fill_idx_q == FW'(k))) begin
                shadow_1_d[k] = psum_norm_1;
                shadow_2_d[k] = psum_norm_2;
            end
        end
        push_row_1[COL-1] = psum_norm_1;
        push_row_2[COL-1] = psum_norm_2;
    end

    // Shift-register FIFO: entry 0 is always the head, so outputs come straight from flops.
    always_comb begin
        pop        = vld_q[0] && m_ready;
        full       = vld_q[DEPTH-1];
        push_ok    = row_done && (!full || pop);
        drop       = row_done && full && !pop;
        overflow_d = overflow_q || drop;
        placed     = 1'b0;
        vld_d      = vld_q;
`ifdef NORM_PACKER_PARITY_EN
        push_par   = {^push_row_2, ^push_row_1};
`endif
        for (int i = 0; i < DEPTH; i++) begin
            mem_1_d[i] = mem_1_q[i];
            mem_2_d[i] = mem_2_q[i];
`ifdef NORM_PACKER_PARITY_EN
            par_d[i]   = par_q[i];
`endif
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_1_d[i] = mem_1_q[i+1];
                mem_2_d[i] = mem_2_q[i+1];
                vld_d[i]   = vld_q[i+1];
`ifdef NORM_PACKER_PARITY_EN
                par_d[i]   = par_q[i+1];
`endif
            end
            vld_d[DEPTH-1] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && !placed && !vld_d[i]) begin
                mem_1_d[i] = push_row_1;
                mem_2_d[i] = push_row_2;
                vld_d[i]   = 1'b1;
`ifdef NORM_PACKER_PARITY_EN
                par_d[i]   = push_par;
`endif
                placed     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fill_idx_q <= '0;
            shadow_1_q <= '0;
            shadow_2_q <= '0;
            vld_q      <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_1_q[i] <= '0;
                mem_2_q[i] <= '0;
`ifdef NORM_PACKER_PARITY_EN
                par_q[i]   <= '0;
`endif
            end
        end else begin
            state_q    <= state_d;
            fill_idx_q <= fill_idx_d;
            shadow_1_q <= shadow_1_d;
            shadow_2_q <= shadow_2_d;
            vld_q      <= vld_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_1_q[i] <= mem_1_d[i];
                mem_2_q[i] <= mem_2_d[i];
`ifdef NORM_PACKER_PARITY_EN
                par_q[i]   <= par_d[i];
`endif
            end
        end
    end

    assign m_valid  = vld_q[0];
    assign row_1    = mem_1_q[0];
    assign row_2    = mem_2_q[0];
    assign fill_idx = fill_idx_q;
    assign overflow = overflow_q;
`ifdef NORM_PACKER_PARITY_EN
    assign row_parity = par_q[0];
`endif

endmodule

// File: tb/tb_norm_packer.sv
// Scoreboard bench for norm_packer: directed rows, expected rows queued at issue,
// monitor compares on every presented head row.
module tb_norm_packer;

    localparam int COL   = 8;
    localparam int W     = 16;
    localparam int DEPTH = 2;

    typedef logic [COL-1:0][W-1:0] row_t;
    typedef struct packed {
        row_t r1;
        row_t r2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        norm_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic [W-1:0] p1 = '0;
    logic [W-1:0] p2 = '0;
    logic        m_valid;
    row_t        row_1, row_2;
    logic [2:0]  fill_idx;
    logic        overflow;
`ifdef NORM_PACKER_PARITY_EN
    logic [1:0]  row_parity;
`endif

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    norm_packer #(.BW_PSUM(16), .COL(COL), .W_OUT(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .norm_valid  (norm_valid),
        .psum_norm_1 (p1),
        .psum_norm_2 (p2),
        .m_ready     (m_ready),
        .m_valid     (m_valid),
        .row_1       (row_1),
        .row_2       (row_2),
        .fill_idx    (fill_idx),
        .overflow    (overflow)
`ifdef NORM_PACKER_PARITY_EN
        ,
        .row_parity  (row_parity)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic row_t mk(input logic [W-1:0] base);
        row_t r;
        for (int k = 0; k < COL; k++) r[k] = base + W'(k);
        return r;
    endfunction

    task automatic expect_row(input row_t r1, input row_t r2);
        exp_t e;
        e.r1 = r1;
        e.r2 = r2;
        sb.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        norm_valid = 1'b1;
        p1 = a;
        p2 = b;
        @(posedge clk);
        #1;
        norm_valid = 1'b0;
    endtask

    task automatic send_row(input logic [W-1:0] b1, input logic [W-1:0] b2);
        for (int k = 0; k < COL; k++) send(b1 + W'(k), b2 + W'(k));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every presented head row is checked; popped on an accepted transfer.
    always @(negedge clk) begin
        if (!reset && m_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_row: got row_1 %h, expected no row", row_1);
            end else begin
                mon_e = sb[0];
                check("row_1", 128'(row_1), 128'(mon_e.r1));
                check("row_2", 128'(row_2), 128'(mon_e.r2));
`ifdef NORM_PACKER_PARITY_EN
                check("row_parity", 128'(row_parity), 128'({^mon_e.r2, ^mon_e.r1}));
`endif
                if (m_ready) begin
                    void'(sb.pop_front());
                    $display("row out: row_1=%h row_2=%h", row_1, row_2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle(2);
        reset = 1'b0;
        check("reset_m_valid",  128'(m_valid),  128'(0));
        check("reset_fill_idx", 128'(fill_idx), 128'(0));
        check("reset_overflow", 128'(overflow), 128'(0));

        // Basic
        m_ready = 1'b1;
        expect_row(mk(16'd10), mk(16'd0));
        send_row(16'd10, 16'd0);
        check("basic_m_valid_on",  128'(m_valid),  128'(1));
        check("basic_fill_idx",    128'(fill_idx), 128'(0));
        idle(1);
        check("basic_m_valid_off", 128'(m_valid),  128'(0));

        // Gaps
        expect_row(mk(16'd10), mk(16'd0));
        for (int k = 0; k < COL; k++) begin
            send(16'd10 + 16'(k), 16'(k));
            check("gap_fill_idx", 128'(fill_idx), 128'((k + 1) % COL));
            if (k < COL - 1) begin
                idle(3);
                check("gap_fill_hold", 128'(fill_idx), 128'(k + 1));
            end
        end
        idle(2);

        // Backpressure / overflow: third row is dropped
        m_ready = 1'b0;
        expect_row(mk(16'h100), mk(16'h110));
        expect_row(mk(16'h200), mk(16'h210));
        send_row(16'h100, 16'h110);
        send_row(16'h200, 16'h210);
        check("bp_overflow_pre", 128'(overflow), 128'(0));
        send_row(16'h300, 16'h310);
        check("bp_overflow_set", 128'(overflow), 128'(1));
        check("bp_m_valid",      128'(m_valid),  128'(1));
        check("bp_head",         128'(row_1),    128'(mk(16'h100)));
        m_ready = 1'b1;
        idle(4);
        check("bp_drained",      128'(m_valid),  128'(0));
        check("bp_overflow_sticky", 128'(overflow), 128'(1));

        // Full + simultaneous pop on the final word of the third row
        pulse_reset();
        check("rst_overflow_clr", 128'(overflow), 128'(0));
        m_ready = 1'b0;
        expect_row(mk(16'h400), mk(16'h410));
        expect_row(mk(16'h500), mk(16'h510));
        expect_row(mk(16'h600), mk(16'h610));
        send_row(16'h400, 16'h410);
        send_row(16'h500, 16'h510);
        for (int k = 0; k < COL - 1; k++) send(16'h600 + 16'(k), 16'h610 + 16'(k));
        m_ready = 1'b1;
        send(16'h607, 16'h617);
        check("fp_overflow", 128'(overflow), 128'(0));
        idle(5);
        check("fp_drained",  128'(m_valid),  128'(0));
        check("fp_overflow_end", 128'(overflow), 128'(0));

        // Reset mid-row
        for (int k = 0; k < 5; k++) send(16'hAA0 + 16'(k), 16'hBB0 + 16'(k));
        check("mid_fill_idx", 128'(fill_idx), 128'(5));
        pulse_reset();
        check("mid_rst_fill_idx", 128'(fill_idx), 128'(0));
        check("mid_rst_m_valid",  128'(m_valid),  128'(0));
        expect_row(mk(16'h50), mk(16'h60));
        send_row(16'h50, 16'h60);
        check("mid_m_valid", 128'(m_valid), 128'(1));
        idle(3);

`ifdef NORM_PACKER_PARITY_EN
        begin
            row_t pr;
            pr = '0;
            pr[0] = 16'h0001;
            expect_row(pr, '0);
            m_ready = 1'b0;
            send(16'h0001, 16'h0000);
            for (int k = 1; k < COL; k++) send(16'h0000, 16'h0000);
            check("parity_value", 128'(row_parity), 128'(2'b01));
            m_ready = 1'b1;
            idle(3);
        end
`endif

        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
